// File: rtl/char_pkg.sv
// Character geometry shared with the sprite draw stage, plus the movement state encoding.
package char_pkg;
   import vga_pkg::*;

   localparam int CHAR_HGT      = 26;
   localparam int CHAR_LNG      = 19;
   localparam int GROUND_OFFSET = 50;

   typedef enum logic [1:0] {
      GROUND  = 2'd0,
      JUMP_UP = 2'd1,
      FALL    = 2'd2
   } char_state_t;
endpackage

// File: rtl/vga_pkg.sv
// Visible VGA raster dimensions shared by every stage of the video pipeline.
package vga_pkg;
   localparam int HOR_PIXELS = 800;
   localparam int VER_PIXELS = 600;
endpackage

// File: rtl/frame_tick_gen.sv
// One-cycle frame strobe, raised the cycle after vblnk is sampled rising.
module frame_tick_gen (
   input  logic clk,
   input  logic rst,
   input  logic vblnk,
   output logic tick
);
   logic vblnk_q, vblnk_d;
   logic tick_q, tick_d;

   always_comb begin
      vblnk_d = vblnk;
      tick_d  = vblnk & ~vblnk_q;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         vblnk_q <= 1'b0;
         tick_q  <= 1'b0;
      end else begin
         vblnk_q <= vblnk_d;
         tick_q  <= tick_d;
      end
   end

   assign tick = tick_q;
endmodule

// File: rtl/char_ctl.sv
// Per-frame character movement: walking, jumping and gravity, clamped to the screen and ground line.
module char_ctl
   import vga_pkg::*;
   import char_pkg::*;
#(
   parameter int MOVE_STEP = 2,
   parameter int JUMP_VEL  = 12,
   parameter int GRAVITY   = 1,
   parameter int MAX_FALL  = 12
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        vblnk,
   input  logic        btn_left,
   input  logic        btn_right,
   input  logic        btn_jump,
   input  logic [1:0]  game_active,
   input  logic [3:0]  current_health,
   output logic [11:0] pos_x,
   output logic [11:0] pos_y,
   output logic        flip_h,
   output logic        on_ground
);
   localparam int GROUND_Y = VER_PIXELS - GROUND_OFFSET - CHAR_HGT;
   localparam int SPAWN_X  = HOR_PIXELS / 5;
   localparam int X_MIN    = CHAR_LNG;
   localparam int X_MAX    = HOR_PIXELS - 1 - CHAR_LNG;
   localparam int Y_MIN    = CHAR_HGT;

   localparam logic signed [12:0] X_MIN_S  = 13'(X_MIN);
   localparam logic signed [12:0] X_MAX_S  = 13'(X_MAX);
   localparam logic signed [12:0] Y_MIN_S  = 13'(Y_MIN);
   localparam logic signed [12:0] GND_Y_S  = 13'(GROUND_Y);
   localparam logic signed [12:0] STEP_S   = 13'(MOVE_STEP);
   localparam logic signed [7:0]  GRAV_S   = 8'(GRAVITY);
   localparam logic signed [7:0]  VEL_MIN  = 8'(-MAX_FALL);

   logic               tick;
   logic [11:0]        pos_x_q, pos_x_d;
   logic [11:0]        pos_y_q, pos_y_d;
   logic signed [7:0]  vel_q, vel_d;
   char_state_t        state_q, state_d;
   logic               flip_q, flip_d;
   logic               on_ground_q, on_ground_d;
   logic               jump_prev_q, jump_prev_d;

   logic               alive, move_l, move_r, jump_req;
   logic signed [12:0] x_ext, y_new;
   logic signed [7:0]  vel_dec;

   frame_tick_gen u_tick (
      .clk   (clk),
      .rst   (rst),
      .vblnk (vblnk),
      .tick  (tick)
   );

   always_comb begin
      pos_x_d     = pos_x_q;
      pos_y_d     = pos_y_q;
      vel_d       = vel_q;
      state_d     = state_q;
      flip_d      = flip_q;
      jump_prev_d = jump_prev_q;
      alive       = |current_health;
      move_l      = alive & btn_left & ~btn_right;
      move_r      = alive & btn_right & ~btn_left;
      jump_req    = btn_jump & ~jump_prev_q;
      x_ext       = $signed({1'b0, pos_x_q});
      y_new       = $signed({1'b0, pos_y_q}) - $signed({{5{vel_q[7]}}, vel_q});
      vel_dec     = vel_q - GRAV_S;
      if (vel_dec < VEL_MIN) vel_dec = VEL_MIN;

      if (tick) begin
         if (game_active != 2'd1) begin
            // Leaving play respawns the character exactly as reset does.
            pos_x_d     = 12'(SPAWN_X);
            pos_y_d     = 12'(GROUND_Y);
            vel_d       = '0;
            state_d     = GROUND;
            flip_d      = 1'b0;
            jump_prev_d = 1'b0;
         end else begin
            jump_prev_d = btn_jump;
            if (move_l) begin
               x_ext  = x_ext - STEP_S;
               flip_d = 1'b1;
            end else if (move_r) begin
               x_ext  = x_ext + STEP_S;
               flip_d = 1'b0;
            end
            if (x_ext < X_MIN_S)      x_ext = X_MIN_S;
            else if (x_ext > X_MAX_S) x_ext = X_MAX_S;
            pos_x_d = x_ext[11:0];

            if (state_q == GROUND) begin
               pos_y_d = 12'(GROUND_Y);
               vel_d   = '0;
               if (jump_req && alive) begin
                  pos_y_d = pos_y_q - 12'(JUMP_VEL);
                  vel_d   = 8'(JUMP_VEL - GRAVITY);
                  state_d = JUMP_UP;
               end
            end else if (y_new >= GND_Y_S) begin
               pos_y_d = 12'(GROUND_Y);
               vel_d   = '0;
               state_d = GROUND;
            end else if (y_new < Y_MIN_S) begin
               pos_y_d = 12'(Y_MIN);
               vel_d   = '0;
               state_d = FALL;
            end else begin
               pos_y_d = y_new[11:0];
               vel_d   = vel_dec;
               if (state_q == JUMP_UP && vel_dec <= 0) state_d = FALL;
            end
         end
      end
      on_ground_d = (state_d == GROUND);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         pos_x_q     <= 12'(SPAWN_X);
         pos_y_q     <= 12'(GROUND_Y);
         vel_q       <= '0;
         state_q     <= GROUND;
         flip_q      <= 1'b0;
         on_ground_q <= 1'b1;
         jump_prev_q <= 1'b0;
      end else begin
         pos_x_q     <= pos_x_d;
         pos_y_q     <= pos_y_d;
         vel_q       <= vel_d;
         state_q     <= state_d;
         flip_q      <= flip_d;
         on_ground_q <= on_ground_d;
         jump_prev_q <= jump_prev_d;
      end
   end

   assign pos_x     = pos_x_q;
   assign pos_y     = pos_y_q;
   assign flip_h    = flip_q;
   assign on_ground = on_ground_q;
endmodule

// File: tb/tb_char_ctl.sv
// Frame-by-frame check of char_ctl: table of button patterns with expected positions, plus hand sequences.
module tb_char_ctl;
   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        vblnk = 1'b0;
   logic        btn_left = 1'b0;
   logic        btn_right = 1'b0;
   logic        btn_jump = 1'b0;
   logic [1:0]  game_active = 2'd1;
   logic [3:0]  current_health = 4'd3;
   logic [11:0] pos_x, pos_y;
   logic        flip_h, on_ground;

   int total = 0;
   int bad = 0;

   typedef struct {
      logic       l, r, j;
      logic [1:0] ga;
      logic [3:0] hp;
      int         rep;
      logic [11:0] ex, ey;
      logic       ef, eg;
   } vec_t;

   typedef struct {
      string       name;
      logic [11:0] x, y;
      logic        f, g;
   } exp_t;

   vec_t vecs[$];
   exp_t sb[$];

   char_ctl dut (
      .clk            (clk),
      .rst            (rst),
      .vblnk          (vblnk),
      .btn_left       (btn_left),
      .btn_right      (btn_right),
      .btn_jump       (btn_jump),
      .game_active    (game_active),
      .current_health (current_health),
      .pos_x          (pos_x),
      .pos_y          (pos_y),
      .flip_h         (flip_h),
      .on_ground      (on_ground)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "timeout");
   end

   function automatic vec_t mk(input logic l, input logic r, input logic j, input logic [1:0] ga,
                               input logic [3:0] hp, input int rep, input int ex, input int ey,
                               input logic ef, input logic eg);
      vec_t v;
      v.l = l; v.r = r; v.j = j; v.ga = ga; v.hp = hp; v.rep = rep;
      v.ex = 12'(ex); v.ey = 12'(ey); v.ef = ef; v.eg = eg;
      return v;
   endfunction

   task automatic push_exp(input string nm, input int x, input int y, input logic f, input logic g);
      exp_t e;
      e.name = nm; e.x = 12'(x); e.y = 12'(y); e.f = f; e.g = g;
      sb.push_back(e);
   endtask

   task automatic cmp(input string nm, input int act, input int exp);
      total++;
      if (act != exp) begin
         bad++;
         $display("FAIL %s: got %0d want %0d", nm, act, exp);
      end
   endtask

   task automatic check_sb();
      exp_t e;
      if (sb.size() == 0) begin
         total++;
         bad++;
         $display("FAIL scoreboard: got empty queue want one entry");
         return;
      end
      e = sb.pop_front();
      cmp({e.name, ".pos_x"}, int'(pos_x), int'(e.x));
      cmp({e.name, ".pos_y"}, int'(pos_y), int'(e.y));
      cmp({e.name, ".flip_h"}, int'(flip_h), int'(e.f));
      cmp({e.name, ".on_ground"}, int'(on_ground), int'(e.g));
      $display("txn %s: pos=(%0d,%0d) flip=%0b gnd=%0b", e.name, pos_x, pos_y, flip_h, on_ground);
   endtask

   task automatic do_tick();
      @(negedge clk) vblnk = 1'b1;
      @(negedge clk) vblnk = 1'b0;
      @(negedge clk);
   endtask

   initial begin
      // ga=1 hp=3 unless stated; expected values are after the last repeated frame.
      vecs.push_back(mk(0,0,0,1,3,  1, 160,524,0,1));
      vecs.push_back(mk(0,0,0,1,3,  1, 160,524,0,1));
      vecs.push_back(mk(0,0,0,1,3,  1, 160,524,0,1));
      vecs.push_back(mk(0,1,0,1,3, 10, 180,524,0,1));
      vecs.push_back(mk(1,0,0,1,3,  1, 178,524,1,1));
      vecs.push_back(mk(1,1,0,1,3,  1, 178,524,1,1));
      vecs.push_back(mk(0,0,1,1,3,  1, 178,512,1,0));
      vecs.push_back(mk(0,0,1,1,3, 10, 178,447,1,0));
      vecs.push_back(mk(0,0,1,1,3,  1, 178,446,1,0));
      vecs.push_back(mk(0,0,1,1,3, 12, 178,512,1,0));
      vecs.push_back(mk(0,0,1,1,3,  1, 178,524,1,1));
      vecs.push_back(mk(0,0,1,1,3,  3, 178,524,1,1));
      vecs.push_back(mk(0,0,0,1,3,  1, 178,524,1,1));
      vecs.push_back(mk(0,0,1,1,3,  1, 178,512,1,0));
      vecs.push_back(mk(0,1,0,1,0, 11, 178,446,1,0));
      vecs.push_back(mk(0,1,0,1,0, 13, 178,524,1,1));
      vecs.push_back(mk(1,0,0,2,0,  1, 160,524,0,1));
      vecs.push_back(mk(1,0,1,1,0,  1, 160,524,0,1));
      vecs.push_back(mk(0,0,0,1,3,  1, 160,524,0,1));
      vecs.push_back(mk(1,0,0,1,3, 70,  20,524,1,1));
      vecs.push_back(mk(1,0,0,1,3,  1,  19,524,1,1));
      vecs.push_back(mk(1,0,0,1,3,  1,  19,524,1,1));
      vecs.push_back(mk(0,1,0,1,3,  1,  21,524,0,1));
      vecs.push_back(mk(1,0,0,1,3,  1,  19,524,1,1));
      vecs.push_back(mk(0,1,0,1,3,380, 779,524,0,1));
      vecs.push_back(mk(0,1,0,1,3,  1, 780,524,0,1));
      vecs.push_back(mk(0,1,0,1,3,  1, 780,524,0,1));

      repeat (3) @(negedge clk);
      push_exp("reset", 160, 524, 1'b0, 1'b1);
      check_sb();
      rst = 1'b0;
      @(negedge clk);

      foreach (vecs[i]) begin
         btn_left       = vecs[i].l;
         btn_right      = vecs[i].r;
         btn_jump       = vecs[i].j;
         game_active    = vecs[i].ga;
         current_health = vecs[i].hp;
         push_exp($sformatf("vec%0d", i), int'(vecs[i].ex), int'(vecs[i].ey), vecs[i].ef, vecs[i].eg);
         for (int k = 0; k < vecs[i].rep; k++) do_tick();
         check_sb();
      end

      // vblnk held high for several cycles must yield a single frame step.
      btn_left = 1'b1; btn_right = 1'b0; btn_jump = 1'b0;
      game_active = 2'd1; current_health = 4'd3;
      push_exp("vblnk_hold", 778, 524, 1'b1, 1'b1);
      @(negedge clk) vblnk = 1'b1;
      repeat (6) @(negedge clk);
      vblnk = 1'b0;
      repeat (2) @(negedge clk);
      check_sb();

      // Outputs hold between frames.
      push_exp("idle_hold", 778, 524, 1'b1, 1'b1);
      repeat (4) @(negedge clk);
      check_sb();

      // Reset while airborne returns to spawn without a frame tick.
      btn_left = 1'b0; btn_jump = 1'b1;
      push_exp("air_jump", 778, 512, 1'b1, 1'b0);
      do_tick();
      check_sb();
      btn_jump = 1'b0;
      push_exp("air_mid", 778, 467, 1'b1, 1'b0);
      repeat (5) do_tick();
      check_sb();
      rst = 1'b1;
      @(negedge clk) rst = 1'b0;
      push_exp("air_rst", 160, 524, 1'b0, 1'b1);
      check_sb();
      push_exp("post_rst", 160, 524, 1'b0, 1'b1);
      do_tick();
      check_sb();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
